// File: rtl/mpt_pkg.sv
// Shared constants and response-entry type for the walker memory responder.
package mpt_pkg;

    localparam int          MPT_DATA_WIDTH      = 64;
    localparam int          MPT_ADDR_WIDTH      = 32;
    localparam int          MPT_MEM_DEPTH       = 256;
    localparam int unsigned MPT_BASE_ADDR       = 0;
    localparam int          MPT_LATENCY         = 2;
    localparam int          MPT_MAX_OUTSTANDING = 2;

    // Widest word a response entry can carry; narrower words are zero-extended.
    localparam int MPT_RESP_DW = MPT_DATA_WIDTH;

    typedef struct packed {
        logic                   valid;
        logic                   error;
        logic [MPT_RESP_DW-1:0] data;
    } mpt_resp_t;

endpackage

// File: rtl/mptw_mem_array.sv
// Word storage with byte-enabled synchronous write and combinational read.
module mptw_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int IW         = 8
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [IW-1:0]           idx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents intentionally survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mptw_mem_responder.sv
// Fixed-latency memory responder for the page-table walker memory port.
module mptw_mem_responder
    import mpt_pkg::*;
#(
    parameter int          DATA_WIDTH      = MPT_DATA_WIDTH,
    parameter int          ADDR_WIDTH      = MPT_ADDR_WIDTH,
    parameter int          MEM_DEPTH       = MPT_MEM_DEPTH,
    parameter int unsigned BASE_ADDR       = MPT_BASE_ADDR,
    parameter int          LATENCY         = MPT_LATENCY,
    parameter int          MAX_OUTSTANDING = MPT_MAX_OUTSTANDING
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    s_mem_req,
    output logic                    s_mem_gnt,
    input  logic [ADDR_WIDTH-1:0]   s_mem_addr,
    input  logic                    s_mem_we,
    input  logic [DATA_WIDTH/8-1:0] s_mem_be,
    input  logic [DATA_WIDTH-1:0]   s_mem_wdata,
    output logic                    s_mem_valid,
    output logic [DATA_WIDTH-1:0]   s_mem_rdata,
    output logic                    s_mem_error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PRE   = (LATENCY > 1) ? LATENCY - 2 : 0;

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(BYTES - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    mpt_resp_t             pipe_q [LATENCY];
    mpt_resp_t             pipe_d [LATENCY];
    mpt_resp_t             head;
    mpt_resp_t             entry;
    logic                  accept;
    logic                  retire;
    logic                  addr_err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] rd;

    always_comb begin
        s_mem_gnt = s_mem_req && !flush_i && !rst_i &&
                    (cnt_q < CW'(MAX_OUTSTANDING));
        accept    = s_mem_req && s_mem_gnt;
        offset    = s_mem_addr - BASE;
        word      = offset >> OFFW;
        addr_err  = ((s_mem_addr & AMASK) != '0) ||
                    (s_mem_addr < BASE) ||
                    (word >= DEPTH);
        mem_we    = accept && s_mem_we && !addr_err;
    end

    mptw_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IW         (IW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .be_i    (s_mem_be),
        .idx_i   (word[IW-1:0]),
        .wdata_i (s_mem_wdata),
        .rdata_o (rd)
    );

    // An entry stops counting as outstanding once it reaches the output stage,
    // so a response and a new accept can overlap in the same cycle.
    always_comb begin
        retire = (LATENCY > 1) ? pipe_q[PRE].valid : accept;

        entry       = '0;
        entry.valid = accept;
        entry.error = accept && addr_err;
        if (accept && !s_mem_we && !addr_err) begin
            entry.data = MPT_RESP_DW'(rd);
        end

        pipe_d[0] = entry;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        cnt_d = cnt_q;
        if (accept && !retire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && retire) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (flush_i) begin
            cnt_d = '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    always_comb begin
        head        = pipe_q[LATENCY-1];
        s_mem_valid = head.valid && !flush_i;
        s_mem_error = head.error && !flush_i;
        s_mem_rdata = flush_i ? '0 : head.data[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_mptw_mem_responder.sv
// Randomized self-checking bench for mptw_mem_responder against a queue model.
module tb_mptw_mem_responder;

    localparam int LAT   = 2;
    localparam int MAXO  = 2;
    localparam int DEPTH = 256;

    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic        req = 0;
    logic        req1 = 0;
    logic [31:0] addr = 0;
    logic        we = 0;
    logic [7:0]  be = 0;
    logic [63:0] wdata = 0;
    logic        gnt, valid, err;
    logic [63:0] rdata;
    logic        gnt1, valid1, err1;
    logic [63:0] rdata1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mem_m [DEPTH];
    logic [63:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    mptw_mem_responder u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .s_mem_req   (req),
        .s_mem_gnt   (gnt),
        .s_mem_addr  (addr),
        .s_mem_we    (we),
        .s_mem_be    (be),
        .s_mem_wdata (wdata),
        .s_mem_valid (valid),
        .s_mem_rdata (rdata),
        .s_mem_error (err)
    );

    mptw_mem_responder #(.MAX_OUTSTANDING(1)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .s_mem_req   (req1),
        .s_mem_gnt   (gnt1),
        .s_mem_addr  (addr),
        .s_mem_we    (we),
        .s_mem_be    (be),
        .s_mem_wdata (wdata),
        .s_mem_valid (valid1),
        .s_mem_rdata (rdata1),
        .s_mem_error (err1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 8 != 0) || (a >= DEPTH * 8);
    endfunction

    // One clock cycle: check outputs at the falling edge, then update the model.
    task automatic step();
        int          pend;
        logic        exp_g;
        logic        e;
        logic [63:0] d;
        int          w;
        @(negedge clk);
        pend = 0;
        foreach (q[i]) if (q[i].due > cyc) pend++;
        exp_g = req && !flush && (pend < MAXO);
        chk("gnt", gnt, exp_g);
        if (q.size() > 0 && q[0].due == cyc && !flush) begin
            chk("valid", valid, 1'b1);
            chk("error", err, q[0].err);
            chk("rdata", rdata, q[0].data);
            last_rdata = rdata;
            last_err   = err;
        end else begin
            chk("idle_valid", valid, 1'b0);
            chk("idle_error", err, 1'b0);
            chk("idle_rdata", rdata, 64'd0);
        end
        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        if (flush) q.delete();
        if (exp_g) begin
            e = bad_addr(addr);
            d = '0;
            w = int'(addr / 8);
            if (!e && we) begin
                for (int b = 0; b < 8; b++)
                    if (be[b]) mem_m[w][b*8 +: 8] = wdata[b*8 +: 8];
            end else if (!e) begin
                d = mem_m[w];
            end
            q.push_back('{due: cyc + LAT, err: e, data: d});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [7:0] b, input logic [63:0] d);
        req = r; we = w; addr = a; be = b; wdata = d;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        #3;
        chk("rst_gnt", gnt, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_error", err, 1'b0);
        chk("rst_rdata", rdata, 64'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Fill all storage with back-to-back writes
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, i * 8, 8'hFF, {$urandom, $urandom});
            step();
        end
        idle(3);

        drive(1, 1, 32'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D); step();
        drive(1, 0, 32'h10, 8'h00, 64'd0); step();
        idle(2);
        chk("rd_full", last_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("rd_full_err", last_err, 1'b0);

        drive(1, 1, 32'h10, 8'h01, 64'h11); step();
        drive(1, 0, 32'h10, 8'h00, 64'd0); step();
        idle(2);
        chk("rd_byte", last_rdata, 64'hDEADBEEF_CAFEF011);

        drive(1, 0, 32'h0C, 8'h00, 64'd0); step();
        idle(2);
        chk("misalign_err", last_err, 1'b1);
        chk("misalign_data", last_rdata, 64'd0);
        drive(1, 1, 32'h800, 8'hFF, 64'h1234); step();
        drive(1, 0, 32'h800, 8'h00, 64'd0); step();
        idle(2);
        chk("oor_err", last_err, 1'b1);
        chk("oor_data", last_rdata, 64'd0);
        drive(1, 0, 32'h10, 8'h00, 64'd0); step();
        idle(2);
        chk("unchanged", last_rdata, 64'hDEADBEEF_CAFEF011);

        // Five-cycle sustained burst
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'(i * 8), 8'h00, 64'd0);
            step();
        end
        idle(3);

        // Single-outstanding instance: grant every other cycle
        drive(0, 0, 32'h10, 8'h00, 64'd0);
        for (int i = 0; i < 8; i++) begin
            req1 = (i < 5);
            @(negedge clk);
            chk("m1_gnt", gnt1, (i < 5) && (i % 2 == 0));
            chk("m1_valid", valid1, (i == 2) || (i == 4) || (i == 6));
            chk("m1_err", err1, 1'b0);
            @(posedge clk);
            #1;
            cyc++;
        end
        req1 = 0;

        // Flush with two reads in flight
        drive(1, 0, 32'h20, 8'h00, 64'd0); step();
        drive(1, 0, 32'h28, 8'h00, 64'd0); step();
        drive(0, 0, 0, 0, 0);
        flush = 1; step();
        flush = 0;
        drive(1, 0, 32'h30, 8'h00, 64'd0); step();
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom_range(0, 255) * 8 + $urandom_range(1, 7);
            else if (r == 1) a = 32'h800 + $urandom_range(0, 1000) * 8;
            else             a = $urandom_range(0, 255) * 8;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a,
                  8'($urandom), {$urandom, $urandom});
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 0;
        idle(3);

        // Reset in the middle of a burst
        drive(1, 1, 32'h40, 8'hFF, 64'h0123_4567_89AB_CDEF); step();
        drive(1, 0, 32'h48, 8'h00, 64'd0); step();
        #2 rst = 1;
        #1;
        chk("arst_gnt", gnt, 1'b0);
        chk("arst_valid", valid, 1'b0);
        chk("arst_error", err, 1'b0);
        chk("arst_rdata", rdata, 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc += 3;
        idle(2);
        drive(1, 0, 32'h40, 8'h00, 64'd0); step();
        idle(2);
        chk("post_rst_data", last_rdata, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 32'($urandom_range(0, 255) * 8), 8'h00, 64'd0);
            step();
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
